bp_uncached_req_queue: RTL and testbench
========================================

BP_UNCACHED_REQ_QUEUE -- requirements
Module: bp_uncached_req_queue

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg, supplying ptag_width_p, page_offset_width_p, paddr_width_p and dword_width_p (64).
REQ-002 SHALL have parameter els_p, default 4, giving queue depth; power of two, at least 2.
REQ-003 clk_i  input  1  sole clock, all state on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-low reset.
REQ-005 req_v_i  input  1  access valid, qualified by the PMA result.
REQ-006 req_uncached_i  input  1  PMA uncached flag for this access.
REQ-007 req_ptag_i  input  ptag_width_p  physical tag.
REQ-008 req_offset_i  input  page_offset_width_p  page offset.
REQ-009 req_store_i  input  1  1 = store, 0 = load.
REQ-010 req_size_i  input  2  log2 of access bytes (0..3).
REQ-011 req_data_i  input  64  store data, right-aligned.
REQ-012 req_ready_o  output  1  queue can accept an entry this cycle.
REQ-013 mem_v_o, mem_ready_i  output/input  1 each  request valid/ready handshake.
REQ-014 mem_addr_o  output  paddr_width_p; mem_store_o  output  1; mem_size_o  output  2; mem_data_o  output  64.
REQ-015 mem_resp_v_i  input  1; mem_resp_data_i  input  64  memory response.
REQ-016 resp_v_o  output  1; resp_data_o  output  64  single-cycle completion pulse to the requester.
REQ-017 busy_o  output  1  queue non-empty or a transaction in flight.

Function
REQ-018 An entry SHALL be enqueued when req_v_i & req_uncached_i & req_ready_o; accesses with req_uncached_i=0 SHALL be ignored.
REQ-019 req_ready_o SHALL equal not-full; a dequeue in the same cycle SHALL NOT make a full queue ready.
REQ-020 Storage SHALL be circular, with read/write pointers carrying an extra wrap bit; full = indices equal and wrap bits differ; empty = pointers equal.
REQ-021 The FSM SHALL have states e_idle, e_send and e_wait.
REQ-022 e_idle: if non-empty, go to e_send next cycle.
REQ-023 e_send: mem_v_o=1 and mem_* driven from the head entry, with mem_addr_o = {ptag, offset}; on mem_v_o & mem_ready_i, go to e_wait.
REQ-024 e_wait: on mem_resp_v_i, pop the head, register the response, go to e_idle.
REQ-025 Only one memory transaction SHALL be outstanding; mem_resp_v_i outside e_wait SHALL be ignored.
REQ-026 resp_v_o SHALL pulse exactly one cycle, the cycle after mem_resp_v_i in e_wait.
REQ-027 resp_data_o SHALL be zero for stores and the load data for loads.
REQ-028 Minimum latency: enqueue at cycle N gives mem_v_o at N+2; response at cycle M gives resp_v_o at M+1.
REQ-029 Requests SHALL be issued strictly in enqueue order.
REQ-030 mem_* outputs SHALL hold stable while mem_v_o=1 and mem_ready_i=0.

Reset
REQ-031 On reset_i low, the block SHALL immediately clear both pointers, set the FSM to e_idle, and drive mem_v_o=0, resp_v_o=0, resp_data_o=0 and busy_o=0.
REQ-032 Reset mid-transaction SHALL discard all entries; a later mem_resp_v_i SHALL be ignored.
REQ-033 Entry storage SHALL NOT require reset.

Configuration
REQ-034 Macro BP_UNCACHED_LOAD_EXTRACT_EN defined: load resp_data_o SHALL be shifted right by 8 × offset[2:0] and zero-extended from 2^size bytes.
REQ-035 Macro undefined: resp_data_o SHALL equal mem_resp_data_i unmodified.

Structure
REQ-036 The queue-entry struct (ptag, offset, store, size, data) SHALL be declared in bp_common_pkg via a declare macro parameterised by bp_params_p.
REQ-037 FSM state enum SHALL be local to the module.
REQ-038 Storage and pointers SHALL live in one sub-module, bp_uncached_req_fifo.

Verification
REQ-039 Uncached load of ptag 0x1, offset 0x008, size 3; mem_ready_i=1; response 0xDEADBEEF_CAFEF00D two cycles later -> mem_addr_o=0x1008; resp_v_o one cycle carrying 0xDEADBEEF_CAFEF00D.
REQ-040 Four stores with mem_ready_i=0 -> req_ready_o=0 after the 4th; a 5th is not enqueued; releasing ready -> four requests issued in order.
REQ-041 req_v_i=1 with req_uncached_i=0 -> no enqueue, busy_o stays 0.
REQ-042 reset_i low during e_wait, then mem_resp_v_i -> resp_v_o stays 0, busy_o=0.
REQ-043 With BP_UNCACHED_LOAD_EXTRACT_EN, load at offset 0x5, size 0, response 0x0000AB00_00000000 -> resp_data_o=0xAB.
REQ-044 mem_ready_i held 0 for 5 cycles in e_send -> mem_v_o and mem_addr_o stable throughout.

Source files
------------

// File: rtl/bp_common_pkg.sv
// Shared processor configuration, uncached-entry declare macro and load extract helper.
// Optional feature macro: BP_UNCACHED_LOAD_EXTRACT_EN (used by bp_uncached_req_queue).
package bp_common_pkg;

  typedef enum logic {
    e_bp_default_cfg
  } bp_params_e;

  typedef struct packed {
    int unsigned ptag_width;
    int unsigned page_offset_width;
    int unsigned paddr_width;
    int unsigned dword_width;
  } bp_proc_param_t;

  function automatic bp_proc_param_t bp_get_params(
    input bp_params_e cfg
  );
    bp_proc_param_t p;
    unique case (cfg)
      e_bp_default_cfg: begin
        p.ptag_width        = 28;
        p.page_offset_width = 12;
        p.paddr_width       = 40;
        p.dword_width       = 64;
      end
      default: begin
        p.ptag_width        = 28;
        p.page_offset_width = 12;
        p.paddr_width       = 40;
        p.dword_width       = 64;
      end
    endcase
    return p;
  endfunction

  // Align the addressed bytes to bit 0, then keep only 2^size bytes.
  function automatic logic [63:0] bp_load_extract(
    input logic [63:0] data,
    input logic [2:0]  off,
    input logic [1:0]  size
  );
    logic [63:0] s;
    logic [63:0] r;
    s = data >> {off, 3'b000};
    r = s;
    unique case (1'b1)
      (size == 2'd0): r = {56'b0, s[7:0]};
      (size == 2'd1): r = {48'b0, s[15:0]};
      (size == 2'd2): r = {32'b0, s[31:0]};
      default:        r = s;
    endcase
    return r;
  endfunction

endpackage

`define BP_DECLARE_UNCACHED_ENTRY_S(ptag_mp, offset_mp, dword_mp) \
  typedef struct packed {                \
    logic [ptag_mp-1:0]   ptag;          \
    logic [offset_mp-1:0] offset;        \
    logic                 store;         \
    logic [1:0]           size;          \
    logic [dword_mp-1:0]  data;          \
  } bp_uncached_entry_t;

// File: rtl/bp_uncached_req_fifo.sv
// Circular entry storage with wrap-bit pointers for the uncached queue.
// Entry storage is not reset; only the pointers are.
module bp_uncached_req_fifo #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enq_i,
  input  logic [width_p-1:0] data_i,
  input  logic               deq_i,
  output logic [width_p-1:0] head_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = $clog2(els_p);

  logic [width_p-1:0] mem_r [els_p];
  logic [ptr_w_lp:0]  wr_ptr_r;
  logic [ptr_w_lp:0]  rd_ptr_r;

  assign empty_o = (wr_ptr_r == rd_ptr_r);
  assign full_o  =
    (wr_ptr_r[ptr_w_lp-1:0] == rd_ptr_r[ptr_w_lp-1:0])
    & (wr_ptr_r[ptr_w_lp] != rd_ptr_r[ptr_w_lp]);
  assign head_o  = mem_r[rd_ptr_r[ptr_w_lp-1:0]];

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (enq_i) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (deq_i) rd_ptr_r <= rd_ptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) mem_r[wr_ptr_r[ptr_w_lp-1:0]] <= data_i;
  end

endmodule

// File: rtl/bp_uncached_req_queue.sv
// In-order uncached request queue, one memory transaction outstanding at a time.
// BP_UNCACHED_LOAD_EXTRACT_EN: align and zero-extend load response data.
module bp_uncached_req_queue
  import bp_common_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int els_p = 4,
  localparam bp_proc_param_t cfg_lp = bp_get_params(bp_params_p),
  localparam int ptag_width_p = int'(cfg_lp.ptag_width),
  localparam int page_offset_width_p = int'(cfg_lp.page_offset_width),
  localparam int paddr_width_p = int'(cfg_lp.paddr_width),
  localparam int dword_width_p = int'(cfg_lp.dword_width)
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           req_v_i,
  input  logic                           req_uncached_i,
  input  logic [ptag_width_p-1:0]        req_ptag_i,
  input  logic [page_offset_width_p-1:0] req_offset_i,
  input  logic                           req_store_i,
  input  logic [1:0]                     req_size_i,
  input  logic [dword_width_p-1:0]       req_data_i,
  output logic                           req_ready_o,
  output logic                           mem_v_o,
  input  logic                           mem_ready_i,
  output logic [paddr_width_p-1:0]       mem_addr_o,
  output logic                           mem_store_o,
  output logic [1:0]                     mem_size_o,
  output logic [dword_width_p-1:0]       mem_data_o,
  input  logic                           mem_resp_v_i,
  input  logic [dword_width_p-1:0]       mem_resp_data_i,
  output logic                           resp_v_o,
  output logic [dword_width_p-1:0]       resp_data_o,
  output logic                           busy_o
);

  `BP_DECLARE_UNCACHED_ENTRY_S(ptag_width_p, page_offset_width_p, dword_width_p)

  typedef enum logic [1:0] {
    e_idle,
    e_send,
    e_wait
  } state_e;

  state_e state_r, state_n;

  bp_uncached_entry_t enq_entry;
  bp_uncached_entry_t head;
  logic [$bits(bp_uncached_entry_t)-1:0] head_bits;

  logic full, empty, enq, deq;
  logic [dword_width_p-1:0] resp_data_n;

  assign enq_entry.ptag   = req_ptag_i;
  assign enq_entry.offset = req_offset_i;
  assign enq_entry.store  = req_store_i;
  assign enq_entry.size   = req_size_i;
  assign enq_entry.data   = req_data_i;

  assign req_ready_o = ~full;
  assign enq = req_v_i & req_uncached_i & ~full;
  assign deq = (state_r == e_wait) & mem_resp_v_i;

  bp_uncached_req_fifo #(
    .width_p($bits(bp_uncached_entry_t)),
    .els_p  (els_p)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .enq_i  (enq),
    .data_i (enq_entry),
    .deq_i  (deq),
    .head_o (head_bits),
    .full_o (full),
    .empty_o(empty)
  );

  assign head = bp_uncached_entry_t'(head_bits);

  assign mem_v_o     = (state_r == e_send);
  assign mem_addr_o  = {head.ptag, head.offset};
  assign mem_store_o = head.store;
  assign mem_size_o  = head.size;
  assign mem_data_o  = head.data;
  assign busy_o      = ~empty | (state_r != e_idle);

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      e_idle:  if (!empty) state_n = e_send;
      e_send:  if (mem_ready_i) state_n = e_wait;
      e_wait:  if (mem_resp_v_i) state_n = e_idle;
      default: state_n = e_idle;
    endcase
  end

  always_comb begin
    resp_data_n = '0;
    if (!head.store) begin
`ifdef BP_UNCACHED_LOAD_EXTRACT_EN
      resp_data_n = bp_load_extract(mem_resp_data_i,
        head.offset[2:0], head.size);
`else
      resp_data_n = mem_resp_data_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_r     <= e_idle;
      resp_v_o    <= 1'b0;
      resp_data_o <= '0;
    end else begin
      state_r  <= state_n;
      resp_v_o <= deq;
      if (deq) resp_data_o <= resp_data_n;
    end
  end

endmodule

// File: tb/tb_bp_uncached_req_queue.sv
// Directed table-driven bench for bp_uncached_req_queue.
// Expected load data follows BP_UNCACHED_LOAD_EXTRACT_EN when defined.
module tb_bp_uncached_req_queue;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_v_i, req_uncached_i, req_store_i;
  logic [27:0] req_ptag_i;
  logic [11:0] req_offset_i;
  logic [1:0]  req_size_i;
  logic [63:0] req_data_i;
  logic        req_ready_o, mem_v_o, mem_ready_i;
  logic [39:0] mem_addr_o;
  logic        mem_store_o;
  logic [1:0]  mem_size_o;
  logic [63:0] mem_data_o;
  logic        mem_resp_v_i;
  logic [63:0] mem_resp_data_i;
  logic        resp_v_o;
  logic [63:0] resp_data_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  bp_uncached_req_queue dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .req_v_i        (req_v_i),
    .req_uncached_i (req_uncached_i),
    .req_ptag_i     (req_ptag_i),
    .req_offset_i   (req_offset_i),
    .req_store_i    (req_store_i),
    .req_size_i     (req_size_i),
    .req_data_i     (req_data_i),
    .req_ready_o    (req_ready_o),
    .mem_v_o        (mem_v_o),
    .mem_ready_i    (mem_ready_i),
    .mem_addr_o     (mem_addr_o),
    .mem_store_o    (mem_store_o),
    .mem_size_o     (mem_size_o),
    .mem_data_o     (mem_data_o),
    .mem_resp_v_i   (mem_resp_v_i),
    .mem_resp_data_i(mem_resp_data_i),
    .resp_v_o       (resp_v_o),
    .resp_data_o    (resp_data_o),
    .busy_o         (busy_o)
  );

  typedef struct {
    logic        unc;
    logic        st;
    logic [27:0] ptag;
    logic [11:0] off;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [39:0] addr;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [5];

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic enq(input logic unc, input logic st,
                     input logic [27:0] ptag, input logic [11:0] off,
                     input logic [1:0] size, input logic [63:0] d);
    req_v_i        = 1'b1;
    req_uncached_i = unc;
    req_store_i    = st;
    req_ptag_i     = ptag;
    req_offset_i   = off;
    req_size_i     = size;
    req_data_i     = d;
    tick;
    req_v_i        = 1'b0;
    req_uncached_i = 1'b0;
  endtask

  task automatic wait_mv(input string name);
    int n = 0;
    while (!mem_v_o && n < 10) begin
      tick;
      n++;
    end
    chk(name, {63'b0, mem_v_o}, 64'd1);
  endtask

  task automatic finish_txn(input logic [63:0] rdata,
                            input logic [63:0] exp);
    mem_ready_i = 1'b1;
    tick;
    mem_ready_i = 1'b0;
    chk("mem_v_drop", {63'b0, mem_v_o}, 64'd0);
    mem_resp_v_i    = 1'b1;
    mem_resp_data_i = rdata;
    tick;
    mem_resp_v_i = 1'b0;
    chk("resp_v_pulse", {63'b0, resp_v_o}, 64'd1);
    chk("resp_data", resp_data_o, exp);
    tick;
    chk("resp_v_end", {63'b0, resp_v_o}, 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 1'b0, 28'h1, 12'h008, 2'd3, 64'h0,
                64'hDEADBEEF_CAFEF00D, 40'h1008,
                64'hDEADBEEF_CAFEF00D};
    vecs[1] = '{1'b1, 1'b1, 28'hABCDE, 12'h3F0, 2'd2,
                64'h11223344, 64'h5555, 40'hABCDE3F0, 64'h0};
    vecs[2] = '{1'b0, 1'b0, 28'h7, 12'h010, 2'd3, 64'h0,
                64'h0, 40'h7010, 64'h0};
`ifdef BP_UNCACHED_LOAD_EXTRACT_EN
    vecs[3] = '{1'b1, 1'b0, 28'h0, 12'h005, 2'd0, 64'h0,
                64'h0000AB00_00000000, 40'h5, 64'hAB};
    vecs[4] = '{1'b1, 1'b0, 28'hFFFFFFF, 12'hFFF, 2'd1, 64'h0,
                64'h12345678_9ABCDEF0, 40'hFF_FFFF_FFFF, 64'h12};
`else
    vecs[3] = '{1'b1, 1'b0, 28'h0, 12'h005, 2'd0, 64'h0,
                64'h0000AB00_00000000, 40'h5,
                64'h0000AB00_00000000};
    vecs[4] = '{1'b1, 1'b0, 28'hFFFFFFF, 12'hFFF, 2'd1, 64'h0,
                64'h12345678_9ABCDEF0, 40'hFF_FFFF_FFFF,
                64'h12345678_9ABCDEF0};
`endif

    reset_i = 1'b0;
    req_v_i = 1'b0;
    req_uncached_i = 1'b0;
    req_store_i = 1'b0;
    req_ptag_i = '0;
    req_offset_i = '0;
    req_size_i = '0;
    req_data_i = '0;
    mem_ready_i = 1'b0;
    mem_resp_v_i = 1'b0;
    mem_resp_data_i = '0;
    tick;
    tick;
    chk("rst_mem_v", {63'b0, mem_v_o}, 64'd0);
    chk("rst_resp_v", {63'b0, resp_v_o}, 64'd0);
    chk("rst_resp_data", resp_data_o, 64'd0);
    chk("rst_busy", {63'b0, busy_o}, 64'd0);
    chk("rst_ready", {63'b0, req_ready_o}, 64'd1);
    reset_i = 1'b1;
    tick;

    for (int i = 0; i < 5; i++) begin
      enq(vecs[i].unc, vecs[i].st, vecs[i].ptag, vecs[i].off,
          vecs[i].size, vecs[i].wdata);
      chk("lat_n1", {63'b0, mem_v_o}, 64'd0);
      chk("busy_enq", {63'b0, busy_o}, {63'b0, vecs[i].unc});
      tick;
      chk("lat_n2", {63'b0, mem_v_o}, {63'b0, vecs[i].unc});
      if (vecs[i].unc) begin
        chk("addr", {24'b0, mem_addr_o}, {24'b0, vecs[i].addr});
        chk("store", {63'b0, mem_store_o}, {63'b0, vecs[i].st});
        chk("size", {62'b0, mem_size_o}, {62'b0, vecs[i].size});
        chk("wdata", mem_data_o, vecs[i].wdata);
        finish_txn(vecs[i].rdata, vecs[i].exp);
      end
      chk("busy_done", {63'b0, busy_o}, 64'd0);
    end

    // fill to full while memory stalls, then drain in order
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", {63'b0, req_ready_o}, 64'd1);
      enq(1'b1, 1'b1, 28'(i + 1), 12'(i * 8), 2'd3,
          64'hA0 + 64'(i));
    end
    chk("full_ready", {63'b0, req_ready_o}, 64'd0);
    enq(1'b1, 1'b1, 28'h99, 12'h0, 2'd3, 64'hBAD);
    chk("full_ready2", {63'b0, req_ready_o}, 64'd0);
    for (int i = 0; i < 4; i++) begin
      wait_mv("drain_mv");
      chk("drain_data", mem_data_o, 64'hA0 + 64'(i));
      chk("drain_addr", {24'b0, mem_addr_o},
          {24'b0, 28'(i + 1), 12'(i * 8)});
      finish_txn(64'hFFFF, 64'h0);
    end
    tick;
    chk("drain_busy", {63'b0, busy_o}, 64'd0);

    // stall in send: outputs must hold
    enq(1'b1, 1'b0, 28'h42, 12'h123, 2'd2, 64'h0);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("stall_v", {63'b0, mem_v_o}, 64'd1);
      chk("stall_addr", {24'b0, mem_addr_o}, 64'h42123);
      tick;
    end
    finish_txn(64'h77, 64'h77);

    // reset during wait discards the in-flight response
    enq(1'b1, 1'b0, 28'h5, 12'h000, 2'd3, 64'h0);
    tick;
    chk("rw_mv", {63'b0, mem_v_o}, 64'd1);
    mem_ready_i = 1'b1;
    tick;
    mem_ready_i = 1'b0;
    reset_i = 1'b0;
    #1;
    chk("rw_busy0", {63'b0, busy_o}, 64'd0);
    chk("rw_mv0", {63'b0, mem_v_o}, 64'd0);
    tick;
    reset_i = 1'b1;
    mem_resp_v_i = 1'b1;
    mem_resp_data_i = 64'h1234;
    tick;
    mem_resp_v_i = 1'b0;
    chk("rw_resp_v", {63'b0, resp_v_o}, 64'd0);
    chk("rw_busy", {63'b0, busy_o}, 64'd0);
    tick;
    chk("rw_resp_v2", {63'b0, resp_v_o}, 64'd0);
    chk("rw_resp_data", resp_data_o, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
